// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALU select encodings and width defaults shared by the ALU request arbiter
package alu_pkg;

  localparam int ALU_LENGTH_WIDTH_DEF     = 32;
  localparam int ALU_SEL_LENGTH_WIDTH_DEF = 4;
  localparam int NUM_REQ_DEF              = 2;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_SLL  = 4'b0010;
  localparam logic [3:0] ALU_SLT  = 4'b0011;
  localparam logic [3:0] ALU_SLTU = 4'b0100;
  localparam logic [3:0] ALU_XOR  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_OR   = 4'b1000;
  localparam logic [3:0] ALU_AND  = 4'b1001;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin grant, search starts at i_ptr and wraps
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_idx
);

  logic w_found;

  // First pass covers ptr..N-1, second pass wraps around to 0..ptr-1.
  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    w_found = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!w_found && i_req[k] && (k >= int'(i_ptr))) begin
        w_found  = 1'b1;
        o_gnt[k] = 1'b1;
        o_idx    = IW'(k);
      end
    end
    for (int k = 0; k < N; k++) begin
      if (!w_found && i_req[k] && (k < int'(i_ptr))) begin
        w_found  = 1'b1;
        o_gnt[k] = 1'b1;
        o_idx    = IW'(k);
      end
    end
  end

endmodule

// File: rtl/alu_req_arbiter.sv
// rtl/alu_req_arbiter.sv - shares one external ALU between requesters with a tagged one-entry response register
module alu_req_arbiter
  import alu_pkg::*;
#(
  parameter int ALU_LENGTH_WIDTH     = ALU_LENGTH_WIDTH_DEF,
  parameter int ALU_SEL_LENGTH_WIDTH = ALU_SEL_LENGTH_WIDTH_DEF,
  parameter int NUM_REQ              = NUM_REQ_DEF,
  parameter int ID_W                 = $clog2(NUM_REQ)
) (
  input  logic                                    i_clk,
  input  logic                                    i_rst,
  input  logic [NUM_REQ-1:0]                      i_req_valid,
  input  logic [NUM_REQ*ALU_LENGTH_WIDTH-1:0]     i_req_op1,
  input  logic [NUM_REQ*ALU_LENGTH_WIDTH-1:0]     i_req_op2,
  input  logic [NUM_REQ*ALU_SEL_LENGTH_WIDTH-1:0] i_req_sel,
  output logic [NUM_REQ-1:0]                      o_req_ready,
  output logic [ALU_LENGTH_WIDTH-1:0]             o_alu1,
  output logic [ALU_LENGTH_WIDTH-1:0]             o_alu2,
  output logic [ALU_SEL_LENGTH_WIDTH-1:0]         o_alu_sel,
  input  logic [ALU_LENGTH_WIDTH-1:0]             i_alu,
  output logic                                    o_rsp_valid,
  output logic [ID_W-1:0]                         o_rsp_id,
  output logic [ALU_LENGTH_WIDTH-1:0]             o_rsp_data,
  input  logic                                    i_rsp_ready,
  output logic                                    o_busy
);

  logic [ID_W-1:0]             r_rr_ptr;
  logic                        r_rsp_valid;
  logic [ID_W-1:0]             r_rsp_id;
  logic [ALU_LENGTH_WIDTH-1:0] r_rsp_data;

  logic [NUM_REQ-1:0] w_gnt;
  logic [ID_W-1:0]    w_idx;
  logic [ID_W-1:0]    w_ptr_next;
  logic               w_can_issue;
  logic               w_accept;

  rr_arbiter #(
    .N  (NUM_REQ),
    .IW (ID_W)
  ) u_rr_arbiter (
    .i_req (i_req_valid),
    .i_ptr (r_rr_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx)
  );

  // The slot may be refilled in the same cycle the consumer drains it.
  assign w_can_issue = ~r_rsp_valid | i_rsp_ready;
  assign o_req_ready = w_can_issue ? w_gnt : '0;
  assign w_accept    = w_can_issue & (|w_gnt);
  assign w_ptr_next  = (w_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;

  // The winner drives the ALU even under backpressure so the path is ready when the slot frees.
  always_comb begin
    o_alu1    = '0;
    o_alu2    = '0;
    o_alu_sel = ALU_SEL_LENGTH_WIDTH'(ALU_ADD);
    for (int k = 0; k < NUM_REQ; k++) begin
      if (w_gnt[k]) begin
        o_alu1    = i_req_op1[k*ALU_LENGTH_WIDTH +: ALU_LENGTH_WIDTH];
        o_alu2    = i_req_op2[k*ALU_LENGTH_WIDTH +: ALU_LENGTH_WIDTH];
        o_alu_sel = i_req_sel[k*ALU_SEL_LENGTH_WIDTH +: ALU_SEL_LENGTH_WIDTH];
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rr_ptr    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_data  <= '0;
    end else if (w_accept) begin
      r_rr_ptr    <= w_ptr_next;
      r_rsp_valid <= 1'b1;
      r_rsp_id    <= w_idx;
      r_rsp_data  <= i_alu;
    end else if (r_rsp_valid && i_rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_id    = r_rsp_id;
  assign o_rsp_data  = r_rsp_data;
  assign o_busy      = r_rsp_valid | (|i_req_valid);

endmodule

// File: tb/tb_alu_req_arbiter.sv
// tb/tb_alu_req_arbiter.sv - vector table plus scoreboarded sequences for alu_req_arbiter with four requesters
module tb_alu_req_arbiter;
  import alu_pkg::*;

  localparam int W  = 32;
  localparam int SW = 4;
  localparam int N  = 4;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    valid = '0;
  logic [W-1:0]    op1 [N];
  logic [W-1:0]    op2 [N];
  logic [SW-1:0]   sel [N];
  logic            rsp_ready = 1'b0;
  logic [N*W-1:0]  req_op1;
  logic [N*W-1:0]  req_op2;
  logic [N*SW-1:0] req_sel;
  logic [N-1:0]    req_ready;
  logic [W-1:0]    alu1, alu2, alu_res;
  logic [SW-1:0]   alu_sel;
  logic            rsp_valid, busy;
  logic [IW-1:0]   rsp_id;
  logic [W-1:0]    rsp_data;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [IW-1:0] id;
    logic [W-1:0]  data;
  } sb_t;
  sb_t sb [$];

  typedef struct {
    logic [N-1:0] valid;
    logic         rsp_ready;
    logic [N-1:0] exp_ready;
    logic [N-1:0] exp_gnt;
    logic         exp_busy;
  } vec_t;
  vec_t vecs [15];

  always #5 clk = ~clk;

  alu_req_arbiter #(
    .ALU_LENGTH_WIDTH     (W),
    .ALU_SEL_LENGTH_WIDTH (SW),
    .NUM_REQ              (N),
    .ID_W                 (IW)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req_valid (valid),
    .i_req_op1   (req_op1),
    .i_req_op2   (req_op2),
    .i_req_sel   (req_sel),
    .o_req_ready (req_ready),
    .o_alu1      (alu1),
    .o_alu2      (alu2),
    .o_alu_sel   (alu_sel),
    .i_alu       (alu_res),
    .o_rsp_valid (rsp_valid),
    .o_rsp_id    (rsp_id),
    .o_rsp_data  (rsp_data),
    .i_rsp_ready (rsp_ready),
    .o_busy      (busy)
  );

  function automatic logic [W-1:0] alu_fn(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [SW-1:0] s);
    case (s)
      ALU_ADD:  return a + b;
      ALU_SUB:  return a - b;
      ALU_SLL:  return a << b[4:0];
      ALU_SLT:  return {31'b0, $signed(a) < $signed(b)};
      ALU_SLTU: return {31'b0, a < b};
      ALU_XOR:  return a ^ b;
      ALU_SRL:  return a >> b[4:0];
      ALU_SRA:  return $unsigned($signed(a) >>> b[4:0]);
      ALU_OR:   return a | b;
      ALU_AND:  return a & b;
      default:  return '0;
    endcase
  endfunction

  always_comb begin
    for (int k = 0; k < N; k++) begin
      req_op1[k*W +: W]   = op1[k];
      req_op2[k*W +: W]   = op2[k];
      req_sel[k*SW +: SW] = sel[k];
    end
    alu_res = alu_fn(alu1, alu2, alu_sel);
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drain first (the response leaving is the older one), then record this cycle's accept.
  always @(negedge clk) begin
    if (!rst) begin
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          chk("sb_unexpected_rsp", 32'd1, 32'd0);
        end else begin
          sb_t e;
          e = sb.pop_front();
          chk("sb_rsp_id", 32'(rsp_id), 32'(e.id));
          chk("sb_rsp_data", rsp_data, e.data);
        end
      end
      for (int k = 0; k < N; k++) begin
        if (valid[k] && req_ready[k]) begin
          sb_t e;
          e.id   = IW'(k);
          e.data = alu_fn(op1[k], op2[k], sel[k]);
          sb.push_back(e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    valid = '0;
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic set_req(input int k, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [SW-1:0] s);
    op1[k] = a;
    op2[k] = b;
    sel[k] = s;
  endtask

  initial begin
    logic [W-1:0]  e1, e2;
    logic [SW-1:0] es;

    set_req(0, 32'h0000_1234, 32'h0000_0034, ALU_SUB);
    set_req(1, 32'hF000_0001, 32'h0000_0004, ALU_SRA);
    set_req(2, 32'h00FF_00FF, 32'h0F0F_0F0F, ALU_XOR);
    set_req(3, 32'h0000_0003, 32'h0000_0005, ALU_SLL);

    vecs[0]  = '{4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0};
    vecs[1]  = '{4'b0001, 1'b1, 4'b0001, 4'b0001, 1'b1};
    vecs[2]  = '{4'b0011, 1'b1, 4'b0010, 4'b0010, 1'b1};
    vecs[3]  = '{4'b0011, 1'b1, 4'b0001, 4'b0001, 1'b1};
    vecs[4]  = '{4'b1111, 1'b1, 4'b0010, 4'b0010, 1'b1};
    vecs[5]  = '{4'b1111, 1'b1, 4'b0100, 4'b0100, 1'b1};
    vecs[6]  = '{4'b1111, 1'b1, 4'b1000, 4'b1000, 1'b1};
    vecs[7]  = '{4'b1111, 1'b1, 4'b0001, 4'b0001, 1'b1};
    vecs[8]  = '{4'b1011, 1'b0, 4'b0000, 4'b0010, 1'b1};
    vecs[9]  = '{4'b1011, 1'b1, 4'b0010, 4'b0010, 1'b1};
    vecs[10] = '{4'b1001, 1'b1, 4'b1000, 4'b1000, 1'b1};
    vecs[11] = '{4'b0001, 1'b1, 4'b0001, 4'b0001, 1'b1};
    vecs[12] = '{4'b0100, 1'b1, 4'b0100, 4'b0100, 1'b1};
    vecs[13] = '{4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b1};
    vecs[14] = '{4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_data", rsp_data, 32'd0);
    chk("reset_rsp_id", 32'(rsp_id), 32'd0);
    chk("reset_rr_ptr", 32'(dut.r_rr_ptr), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 15; i++) begin
      valid     = vecs[i].valid;
      rsp_ready = vecs[i].rsp_ready;
      #2;
      e1 = '0;
      e2 = '0;
      es = ALU_ADD;
      for (int k = 0; k < N; k++) begin
        if (vecs[i].exp_gnt[k]) begin
          e1 = op1[k];
          e2 = op2[k];
          es = sel[k];
        end
      end
      chk($sformatf("vec%0d_ready", i), 32'(req_ready), 32'(vecs[i].exp_ready));
      chk($sformatf("vec%0d_alu1", i), alu1, e1);
      chk($sformatf("vec%0d_alu2", i), alu2, e2);
      chk($sformatf("vec%0d_sel", i), 32'(alu_sel), 32'(es));
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].exp_busy));
      tick();
    end

    do_reset();
    set_req(0, 32'd5, 32'd3, ALU_SUB);
    valid = 4'b0001;
    rsp_ready = 1'b1;
    #2;
    chk("single_ready", 32'(req_ready), 32'b0001);
    tick();
    valid = '0;
    chk("single_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("single_rsp_data", rsp_data, 32'd2);
    chk("single_rsp_id", 32'(rsp_id), 32'd0);
    tick();

    do_reset();
    set_req(1, 32'd7, 32'd9, ALU_ADD);
    set_req(0, 32'd20, 32'd6, ALU_SUB);
    valid = 4'b0010;
    rsp_ready = 1'b1;
    tick();
    valid = 4'b0001;
    rsp_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #2;
      chk("bp_ready", 32'(req_ready), 32'd0);
      chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_rsp_data", rsp_data, 32'd16);
      chk("bp_rsp_id", 32'(rsp_id), 32'd1);
      chk("bp_rr_ptr", 32'(dut.r_rr_ptr), 32'd2);
      tick();
    end
    rsp_ready = 1'b1;
    #2;
    chk("bp_release_ready", 32'(req_ready), 32'b0001);
    tick();
    valid = '0;
    chk("bp_reload_valid", 32'(rsp_valid), 32'd1);
    chk("bp_reload_data", rsp_data, 32'd14);
    chk("bp_reload_id", 32'(rsp_id), 32'd0);
    tick();
    chk("bp_drained", 32'(rsp_valid), 32'd0);

    do_reset();
    set_req(3, 32'h11, 32'h2, ALU_SLL);
    valid = 4'b1000;
    rsp_ready = 1'b1;
    #2;
    chk("wrap_ready3", 32'(req_ready), 32'b1000);
    tick();
    chk("wrap_ptr", 32'(dut.r_rr_ptr), 32'd0);
    valid = 4'b0001;
    #2;
    chk("wrap_ready0", 32'(req_ready), 32'b0001);
    tick();
    valid = '0;
    tick();

    set_req(2, 32'hAAAA_0000, 32'h0000_5555, ALU_OR);
    valid = 4'b0100;
    rsp_ready = 1'b0;
    tick();
    valid = '0;
    #1;
    chk("rstmid_pre_valid", 32'(rsp_valid), 32'd1);
    rst = 1'b1;
    sb.delete();
    #1;
    chk("rstmid_valid", 32'(rsp_valid), 32'd0);
    chk("rstmid_data", rsp_data, 32'd0);
    chk("rstmid_id", 32'(rsp_id), 32'd0);
    chk("rstmid_ptr", 32'(dut.r_rr_ptr), 32'd0);
    tick();
    rst = 1'b0;
    valid = 4'b0011;
    rsp_ready = 1'b1;
    #2;
    chk("rstmid_next_grant", 32'(req_ready), 32'b0001);
    tick();
    valid = '0;

    #2;
    chk("idle_alu1", alu1, 32'd0);
    chk("idle_alu2", alu2, 32'd0);
    chk("idle_sel", 32'(alu_sel), 32'(ALU_ADD));
    chk("idle_ready", 32'(req_ready), 32'd0);
    chk("idle_busy_pending", 32'(busy), 32'd1);
    tick();
    chk("idle_busy", 32'(busy), 32'd0);
    tick();
    chk("sb_empty_at_end", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_req_arbiter.md
# alu_req_arbiter

Round-robin arbiter and sequencer sharing the single RV32I ALU between `NUM_REQ` requesters, for example the execute stage and the branch/address unit. It grants at most one request per cycle and drives the ALU operand and select lines combinationally from the winner. The ALU result is captured into a one-entry response register, tagged with the requester ID, and handed back under a valid/ready handshake with backpressure.

## Interface
- `ALU_LENGTH_WIDTH`, 32: operand/result width.
- `ALU_SEL_LENGTH_WIDTH`, 4: ALU select width.
- `NUM_REQ`, 2: number of requesters, 2..8.
- `ID_W`, `$clog2(NUM_REQ)`: requester ID width.

Ports:
- `i_clk` in 1: clock.
- `i_rst` in 1: reset, asynchronous, active-high.
- `i_req_valid` in `NUM_REQ`: per-requester request valid.
- `i_req_op1` in `NUM_REQ*ALU_LENGTH_WIDTH`: packed operand 1; requester k occupies slice k.
- `i_req_op2` in `NUM_REQ*ALU_LENGTH_WIDTH`: packed operand 2.
- `i_req_sel` in `NUM_REQ*ALU_SEL_LENGTH_WIDTH`: packed ALU select.
- `o_req_ready` out `NUM_REQ`: per-requester accept; one-hot or zero.
- `o_alu1`, `o_alu2` out `ALU_LENGTH_WIDTH`: operands to the ALU.
- `o_alu_sel` out `ALU_SEL_LENGTH_WIDTH`: select to the ALU.
- `i_alu` in `ALU_LENGTH_WIDTH`: ALU result (combinational from `o_alu*`).
- `o_rsp_valid` out 1: response valid.
- `o_rsp_id` out `ID_W`: ID of the requester owning the response.
- `o_rsp_data` out `ALU_LENGTH_WIDTH`: registered ALU result.
- `i_rsp_ready` in 1: consumer accepts the response.
- `o_busy` out 1: `o_rsp_valid` OR any `i_req_valid`.

## Operation
- `can_issue = ~o_rsp_valid | i_rsp_ready`. The response slot is free or drains this cycle.
- Arbitration:
  - Round-robin pointer `rr_ptr` (`ID_W` bits).
  - Search starts at `rr_ptr` and wraps modulo `NUM_REQ`.
  - The first requester with valid set wins (`gnt`, one-hot).
- `o_req_ready = gnt` when `can_issue`, else 0.
- Accept for requester k = `i_req_valid[k] & o_req_ready[k]`.
- On accept of requester k:
  - `rr_ptr <= (k+1) mod NUM_REQ`.
  - The response register loads `i_alu`, `o_rsp_id <= k`, and `o_rsp_valid <= 1`.
- With no accept, `rr_ptr` holds.
- ALU drive:
  - When `gnt` is nonzero, `o_alu1`/`o_alu2`/`o_alu_sel` carry the winner's slices, even when `can_issue` is 0.
  - Otherwise they are 0 / 0 / `ALU_ADD`.
- Response drain: when `o_rsp_valid & i_rsp_ready` with no new accept, `o_rsp_valid <= 0`. Data and ID hold their last values.
- Simultaneous drain and accept: the register reloads with the new result and `o_rsp_valid` stays 1. This sustains one result per cycle.
- Backpressure: while `o_rsp_valid & ~i_rsp_ready`, all readies are 0. Data, ID and valid hold stable.
- Requester rules:
  - Once valid is asserted, hold it and the payload stable until accepted.
  - Valid must not depend on ready.
  - Ready may depend on valid.
- Reset mid-operation: a pending response is discarded and the pointer returns to 0.

## Timing
- Reset values:
  - `o_rsp_valid` 0, `o_rsp_data` 0, `o_rsp_id` 0, `rr_ptr` 0.
  - `o_req_ready`, `o_alu*` and `o_busy` are combinational and follow the inputs.
- Latency: a request accepted in cycle N appears on `o_rsp_valid` and `o_rsp_data` in cycle N+1.
- Throughput: one accept per cycle. With all requesters valid and no backpressure, grants rotate 0,1,…,`NUM_REQ`-1,0.
- Starvation bound: a continuously valid requester is granted within `NUM_REQ` issue-able cycles.
- Combinational path: `i_req_valid` → `gnt` → `o_alu*` → (external ALU) → `i_alu` → response register D. `i_rsp_ready` → `o_req_ready` is also combinational.

## Structure
- Package `alu_pkg` holds:
  - the select constants `ALU_ADD`=4'b0000, `ALU_SUB`=0001, `ALU_SLL`=0010, `ALU_SLT`=0011, `ALU_SLTU`=0100, `ALU_XOR`=0101, `ALU_SRL`=0110, `ALU_SRA`=0111, `ALU_OR`=1000, `ALU_AND`=1001;
  - the width defaults.
- Sub-module `rr_arbiter` (parameter `N`):
  - inputs: request vector, pointer;
  - output: one-hot grant plus encoded index;
  - purely combinational.
- The pointer and response registers live in `alu_req_arbiter`. The ALU stays outside and is connected at the next level up.

## Test plan
- Single request: after reset, req0 issues op1=5, op2=3, sel=`ALU_SUB`. The bench's ALU model returns 2. Expect `o_req_ready`=01 in cycle N, then `o_rsp_valid`=1, `o_rsp_data`=2, `o_rsp_id`=0 in N+1.
- Contention: both requesters valid continuously with `i_rsp_ready`=1. Expect grants 0,1,0,1 on consecutive cycles and responses back-to-back with IDs 0,1,0,1.
- Backpressure: response pending and `i_rsp_ready`=0 for 3 cycles. Expect `o_req_ready`=0, response fields frozen, and `rr_ptr` unchanged. On the ready cycle, a new accept occurs in the same cycle and `o_rsp_valid` stays 1.
- Pointer wrap: `NUM_REQ`=4, only req3 then req0 valid. Expect a grant to 3, then `rr_ptr`=0, then a grant to 0.
- Reset mid-operation: assert `i_rst` asynchronously while `o_rsp_valid`=1 and `i_rsp_ready`=0. Expect `o_rsp_valid`=0, `o_rsp_data`=0, `o_rsp_id`=0 immediately, and the next grant goes to req0.
- Idle drive: no valids. Expect `o_alu1`=0, `o_alu2`=0, `o_alu_sel`=`ALU_ADD`, `o_req_ready`=0, and `o_busy`=0 once the response drains.
